// File: rtl/network_pkg.sv
// Shared constants and types for the SNN network.
// Holds the network size and the output decoder's defaults and state encoding.
package network_pkg;

   localparam int OUTPUT_SIZE   = 10;

   localparam int DEC_WINDOW    = 64;
   localparam int DEC_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      ARGMAX = 2'd2,
      DONE   = 2'd3
   } dec_state_e;

endpackage

// File: rtl/snn_spike_decoder_if.sv
// Bus between the SNN output stage and the spike decoder.
// Producer/consumer side (master):
//   drives start, spike_valid, digit_spikes, result_ready;
//   sees busy, result_valid, result_digit, result_count, no_spike.
// Decoder side (slave): the reverse directions.
interface snn_spike_decoder_if #(
   parameter int OUTPUT_SIZE = network_pkg::OUTPUT_SIZE,
   parameter int CNT_WIDTH   = network_pkg::DEC_CNT_WIDTH
);
   localparam int IDX_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

   logic                 start;
   logic                 spike_valid;
   logic                 digit_spikes [OUTPUT_SIZE];
   logic                 busy;
   logic                 result_valid;
   logic                 result_ready;
   logic [IDX_W-1:0]     result_digit;
   logic [CNT_WIDTH-1:0] result_count;
   logic                 no_spike;

   modport master (
      output start, spike_valid, digit_spikes, result_ready,
      input  busy, result_valid, result_digit, result_count, no_spike
   );

   modport slave (
      input  start, spike_valid, digit_spikes, result_ready,
      output busy, result_valid, result_digit, result_count, no_spike
   );

endinterface

// File: rtl/spike_counter_sat.sv
// Single saturating spike counter.
// Ports: clk, rst_n (async, active-low), clr (synchronous clear, wins over inc),
//        inc (add one unless already at all-ones), cnt (current count).
module spike_counter_sat #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/snn_spike_decoder.sv
// Output-side decoder: counts spikes per output neuron over WINDOW accepted
// timesteps, then scans the counters one per cycle for the largest count
// (ties go to the lowest index) and holds the winner on a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), bus (decoder side of snn_spike_decoder_if).
//
// state  | meaning
// IDLE   | waiting for start; result registers keep last value
// ACCUM  | counting spikes on each spike_valid until WINDOW strobes seen
// ARGMAX | scanning counter k, keeping strictly larger counts
// DONE   | result_valid high until result_ready
module snn_spike_decoder #(
   parameter int OUTPUT_SIZE = network_pkg::OUTPUT_SIZE,
   parameter int WINDOW      = network_pkg::DEC_WINDOW,
   parameter int CNT_WIDTH   = network_pkg::DEC_CNT_WIDTH
) (
   input logic               clk,
   input logic               rst_n,
   snn_spike_decoder_if.slave bus
);
   import network_pkg::*;

   localparam int IDX_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
   localparam int TS_W  = $clog2(WINDOW + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
   localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(WINDOW - 1);

   dec_state_e           state_q, state_d;
   logic [TS_W-1:0]      tstep_q;
   logic [IDX_W-1:0]     k_q;
   logic [IDX_W-1:0]     best_idx_q;
   logic [CNT_WIDTH-1:0] best_cnt_q;
   logic                 no_spike_q;
   logic [CNT_WIDTH-1:0] cnt [OUTPUT_SIZE];
   logic [CNT_WIDTH-1:0] cand_cnt;
   logic                 cand_gt;
   logic                 clr_cnt;
   logic                 accept;

   for (genvar i = 0; i < OUTPUT_SIZE; i++) begin : g_cnt
      spike_counter_sat #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr_cnt),
         .inc   (accept && bus.digit_spikes[i]),
         .cnt   (cnt[i])
      );
   end

   assign cand_cnt = cnt[k_q];
   assign cand_gt  = cand_cnt > best_cnt_q;

   always_comb begin
      state_d = state_q;
      clr_cnt = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               clr_cnt = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.spike_valid) begin
               accept = 1'b1;
               if (tstep_q == LAST_TS) state_d = ARGMAX;
            end
         end
         ARGMAX: begin
            if (k_q == LAST_IDX) state_d = DONE;
         end
         DONE: begin
            if (bus.result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tstep_q    <= '0;
         k_q        <= '0;
         best_idx_q <= '0;
         best_cnt_q <= '0;
         no_spike_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  tstep_q    <= '0;
                  k_q        <= '0;
                  best_idx_q <= '0;
                  best_cnt_q <= '0;
                  no_spike_q <= 1'b0;
               end
            end
            ACCUM: begin
               if (bus.spike_valid) tstep_q <= tstep_q + 1'b1;
            end
            ARGMAX: begin
               k_q <= k_q + 1'b1;
               if (cand_gt) begin
                  best_idx_q <= k_q;
                  best_cnt_q <= cand_cnt;
               end
               // The final best is zero only if both the running best and
               // the last candidate are zero.
               if (k_q == LAST_IDX) begin
                  no_spike_q <= (best_cnt_q == '0) && (cand_cnt == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.result_valid = (state_q == DONE);
   assign bus.result_digit = best_idx_q;
   assign bus.result_count = best_cnt_q;
   assign bus.no_spike     = no_spike_q;

endmodule

// File: tb/tb_snn_spike_decoder.sv
module tb_snn_spike_decoder;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   snn_spike_decoder_if #(.OUTPUT_SIZE(10), .CNT_WIDTH(8)) bus0 ();
   snn_spike_decoder_if #(.OUTPUT_SIZE(10), .CNT_WIDTH(4)) bus1 ();

   snn_spike_decoder #(.OUTPUT_SIZE(10), .WINDOW(64), .CNT_WIDTH(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   snn_spike_decoder #(.OUTPUT_SIZE(10), .WINDOW(64), .CNT_WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   // narrow-counter instance sees the same stimulus
   assign bus1.start        = bus0.start;
   assign bus1.spike_valid  = bus0.spike_valid;
   assign bus1.digit_spikes = bus0.digit_spikes;
   assign bus1.result_ready = bus0.result_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mask(input logic [9:0] mask);
      for (int j = 0; j < 10; j++) bus0.digit_spikes[j] = mask[j];
   endtask

   task automatic start_window();
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
   endtask

   task automatic run_strobes(input int n, input logic [9:0] mask);
      for (int i = 0; i < n; i++) begin
         bus0.spike_valid = 1'b1;
         set_mask(mask);
         tick();
      end
      bus0.spike_valid = 1'b0;
      set_mask(10'b0);
   endtask

   task automatic run_gapped(input int n, input logic [9:0] mask);
      for (int i = 0; i < n; i++) begin
         bus0.spike_valid = 1'b0;
         set_mask(10'b0);
         tick();
         bus0.spike_valid = 1'b1;
         set_mask(mask);
         tick();
      end
      bus0.spike_valid = 1'b0;
      set_mask(10'b0);
   endtask

   // Returns the number of edges until result_valid is seen (0 if never).
   task automatic wait_valid(output int cyc);
      cyc = 0;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (bus0.result_valid === 1'b1) begin
            cyc = c;
            break;
         end
      end
   endtask

   int cyc;

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus0.start = 1'b0;
      bus0.spike_valid = 1'b0;
      bus0.result_ready = 1'b0;
      set_mask(10'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // reset values
      chk("rst_busy",     32'(bus0.busy),         0);
      chk("rst_valid",    32'(bus0.result_valid), 0);
      chk("rst_digit",    32'(bus0.result_digit), 0);
      chk("rst_count",    32'(bus0.result_count), 0);
      chk("rst_no_spike", 32'(bus0.no_spike),     0);

      // reset in the middle of ACCUM
      start_window();
      chk("t1_busy_after_start", 32'(bus0.busy), 1);
      run_strobes(20, 10'b0000001000);
      chk("t1_busy_mid_accum", 32'(bus0.busy), 1);
      rst_n = 1'b0;
      #2;
      chk("t1_async_busy",     32'(bus0.busy),         0);
      chk("t1_async_valid",    32'(bus0.result_valid), 0);
      chk("t1_async_digit",    32'(bus0.result_digit), 0);
      chk("t1_async_count",    32'(bus0.result_count), 0);
      chk("t1_async_no_spike", 32'(bus0.no_spike),     0);
      tick();
      rst_n = 1'b1;
      tick();

      // fresh window: neuron 3 every strobe, ready held high in advance
      bus0.result_ready = 1'b1;
      start_window();
      run_strobes(64, 10'b0000001000);
      chk("t2_busy_before_result", 32'(bus0.busy), 1);
      wait_valid(cyc);
      chk("t2_latency",  32'(cyc), 10);
      chk("t2_digit",    32'(bus0.result_digit), 3);
      chk("t2_count",    32'(bus0.result_count), 64);
      chk("t2_no_spike", 32'(bus0.no_spike), 0);
      tick();
      chk("t2_valid_one_cycle", 32'(bus0.result_valid), 0);
      chk("t2_idle_busy",       32'(bus0.busy), 0);

      // tie between neurons 2 and 7
      start_window();
      run_strobes(30, 10'b0010000100);
      run_strobes(34, 10'b0000000000);
      wait_valid(cyc);
      chk("t3_latency", 32'(cyc), 10);
      chk("t3_digit",   32'(bus0.result_digit), 2);
      chk("t3_count",   32'(bus0.result_count), 30);
      tick();

      // saturation: neuron 5 x64, neuron 1 x14
      start_window();
      run_strobes(14, 10'b0000100010);
      run_strobes(50, 10'b0000100000);
      wait_valid(cyc);
      chk("t4_latency",     32'(cyc), 10);
      chk("t4_w8_digit",    32'(bus0.result_digit), 5);
      chk("t4_w8_count",    32'(bus0.result_count), 64);
      chk("t4_w4_valid",    32'(bus1.result_valid), 1);
      chk("t4_w4_digit",    32'(bus1.result_digit), 5);
      chk("t4_w4_count",    32'(bus1.result_count), 15);
      chk("t4_w4_no_spike", 32'(bus1.no_spike), 0);
      tick();

      // all-zero window
      start_window();
      run_strobes(64, 10'b0000000000);
      wait_valid(cyc);
      chk("t5_latency",  32'(cyc), 10);
      chk("t5_digit",    32'(bus0.result_digit), 0);
      chk("t5_count",    32'(bus0.result_count), 0);
      chk("t5_no_spike", 32'(bus0.no_spike), 1);
      tick();

      // gaps, start pulse in ACCUM, backpressure, start pulse in DONE
      bus0.result_ready = 1'b0;
      start_window();
      run_gapped(40, 10'b1000000000);
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      chk("t6_busy_after_accum_start", 32'(bus0.busy), 1);
      bus0.spike_valid = 1'b1;
      set_mask(10'b1000000000);
      tick();
      run_gapped(23, 10'b1000000000);
      wait_valid(cyc);
      chk("t6_latency", 32'(cyc), 10);
      chk("t6_digit",   32'(bus0.result_digit), 9);
      chk("t6_count",   32'(bus0.result_count), 64);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) bus0.start = 1'b1;
         tick();
         bus0.start = 1'b0;
         chk("t6_hold_valid", 32'(bus0.result_valid), 1);
         chk("t6_hold_digit", 32'(bus0.result_digit), 9);
         chk("t6_hold_count", 32'(bus0.result_count), 64);
      end
      bus0.result_ready = 1'b1;
      tick();
      chk("t6_valid_dropped", 32'(bus0.result_valid), 0);
      chk("t6_idle_busy",     32'(bus0.busy), 0);

      // back-to-back: start in the first IDLE cycle after the handshake
      start_window();
      chk("t7_busy", 32'(bus0.busy), 1);
      run_strobes(64, 10'b0000000001);
      wait_valid(cyc);
      chk("t7_latency",  32'(cyc), 10);
      chk("t7_digit",    32'(bus0.result_digit), 0);
      chk("t7_count",    32'(bus0.result_count), 64);
      chk("t7_no_spike", 32'(bus0.no_spike), 0);
      tick();
      chk("t7_valid_dropped", 32'(bus0.result_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
